// File: rtl/serial_logic_unit.sv
// Serial bitwise logic unit: WIDTH-bit operands processed SLICE bits per clock, LSB slice first.
// Optional LOGIC_FLAGS_EN adds registered zero_flag / ones_flag outputs alongside result.
module serial_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC_FLAGS_EN
    output logic             zero_flag,
    output logic             ones_flag,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ones_q, ones_d;

    logic [SLICE-1:0]   slice_res;
    logic [WIDTH-1:0]   acc_next;

    // One slice of the selected bitwise operation; anything unlisted is PASS a.
    function automatic logic [SLICE-1:0] slice_op(
        input logic [2:0]       f,
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y
    );
        logic [SLICE-1:0] r;
        case (f)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_NOR:  r = ~(x | y);
            OP_NAND: r = ~(x & y);
            OP_XOR:  r = x ^ y;
            OP_XNOR: r = ~(x ^ y);
            OP_NOTA: r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        slice_res = slice_op(op_q, a_q[SLICE-1:0], b_q[SLICE-1:0]);
        // New slice enters at the top so the first (LSB) slice ends at bit 0 after N shifts.
        acc_next  = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
    end

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ones_d    = ones_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_RUN: begin
                acc_d = acc_next;
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    result_d = acc_next;
                    zero_d   = (acc_next == '0);
                    ones_d   = &acc_next;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept path shared by IDLE and the no-bubble DONE handoff.
        if (in_ready && in_valid) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ones_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ones_q   <= ones_d;
        end
    end

    assign result = result_q;

`ifdef LOGIC_FLAGS_EN
    assign zero_flag = zero_q;
    assign ones_flag = ones_q;
`else
    logic unused_flags;
    assign unused_flags = zero_q ^ ones_q;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: one SLICE=1 and one SLICE=4 instance sharing clock and reset.
module tb_serial_logic_unit;

    logic clk;
    logic rst_n;

    logic       iv1, ir1, ov1, or1;
    logic [2:0] op1;
    logic [7:0] a1, b1, r1;
    logic       iv4, ir4, ov4, or4;
    logic [2:0] op4;
    logic [7:0] a4, b4, r4;
`ifdef LOGIC_FLAGS_EN
    logic z1, o1, z4, o4;
`endif

    int n_pass;
    int n_chk;
    int lat;
    int seen;

    serial_logic_unit #(.WIDTH(8), .SLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1),
`ifdef LOGIC_FLAGS_EN
        .zero_flag(z1), .ones_flag(o1),
`endif
        .result(r1)
    );

    serial_logic_unit #(.WIDTH(8), .SLICE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
`ifdef LOGIC_FLAGS_EN
        .zero_flag(z4), .ones_flag(o4),
`endif
        .result(r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present an op to the SLICE=1 unit, accept it, then scramble the inputs.
    task automatic launch1(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        iv1 = 1'b1; op1 = f; a1 = x; b1 = y;
        chk("ready1_before_accept", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        iv1 = 1'b0; op1 = ~f; a1 = ~x; b1 = ~y;
    endtask

    task automatic launch4(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        iv4 = 1'b1; op4 = f; a4 = x; b4 = y;
        chk("ready4_before_accept", 32'(ir4), 32'd1);
        @(posedge clk); #1;
        iv4 = 1'b0; op4 = ~f; a4 = ~x; b4 = ~y;
    endtask

    // Count edges from accept until out_valid, bounded.
    task automatic wait1(input string tag, input int exp_lat, input logic [7:0] exp);
        lat = 0;
        while (ov1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, 32'(r1), 32'(exp));
    endtask

    task automatic wait4(input string tag, input int exp_lat, input logic [7:0] exp);
        lat = 0;
        while (ov4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, 32'(r4), 32'(exp));
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        rst_n = 1'b0;
        iv1 = 0; op1 = 0; a1 = 0; b1 = 0; or1 = 1;
        iv4 = 0; op4 = 0; a4 = 0; b4 = 0; or4 = 1;
        #12;
        chk("rst_ready1", 32'(ir1), 32'd1);
        chk("rst_valid1", 32'(ov1), 32'd0);
        chk("rst_result1", 32'(r1), 32'd0);
        chk("rst_valid4", 32'(ov4), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // NOR 00,00 -> FF after 8 edges
        launch1(3'b010, 8'h00, 8'h00);
        chk("run_ready1", 32'(ir1), 32'd0);
        wait1("nor00", 8, 8'hFF);
`ifdef LOGIC_FLAGS_EN
        chk("nor00_ones", 32'(o1), 32'd1);
        chk("nor00_zero", 32'(z1), 32'd0);
`endif
        @(posedge clk); #1;
        chk("nor00_drop", 32'(ov1), 32'd0);
        chk("nor00_idle_ready", 32'(ir1), 32'd1);
        chk("nor00_hold", 32'(r1), 32'hFF);

        launch1(3'b010, 8'hF0, 8'h0F);
        wait1("norF0", 8, 8'h00);
`ifdef LOGIC_FLAGS_EN
        chk("norF0_zero", 32'(z1), 32'd1);
`endif
        launch1(3'b011, 8'hFF, 8'hFF);
        wait1("nandFF", 8, 8'h00);
        launch1(3'b101, 8'h3C, 8'h3C);
        wait1("xnor3C", 8, 8'hFF);

        // SLICE=4 unit
        launch4(3'b100, 8'hA5, 8'hFF);
        wait4("xorA5", 2, 8'h5A);
        launch4(3'b110, 8'h0F, 8'h33);
        wait4("not0F", 2, 8'hF0);
        launch4(3'b111, 8'h81, 8'h7E);
        wait4("pass81", 2, 8'h81);

        // Backpressure
        @(negedge clk); or1 = 1'b0;
        launch1(3'b000, 8'hCC, 8'hAA);
        wait1("andCC", 8, 8'h88);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(ov1), 32'd1);
            chk("bp_result", 32'(r1), 32'h88);
            chk("bp_ready", 32'(ir1), 32'd0);
        end
        @(negedge clk); or1 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(ov1), 32'd0);
        chk("bp_release_ready", 32'(ir1), 32'd1);

        // Back-to-back with in_valid held, no bubble
        @(negedge clk);
        iv1 = 1'b1; op1 = 3'b001; a1 = 8'h01; b1 = 8'h10;
        @(posedge clk); #1;
        a1 = 8'h02; b1 = 8'h20;
        wait1("b2b_first", 8, 8'h11);
        chk("b2b_done_ready", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("b2b_accept_valid", 32'(ov1), 32'd0);
        wait1("b2b_second", 8, 8'h22);
        @(posedge clk); #1;
        chk("b2b_idle", 32'(ov1), 32'd0);

        // Reset mid-RUN
        launch1(3'b001, 8'hFF, 8'h00);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(ov1), 32'd0);
        chk("abort_result", 32'(r1), 32'd0);
        chk("abort_ready", 32'(ir1), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov1 === 1'b1) seen++;
        end
        chk("abort_no_emit", 32'(seen), 32'd0);
        chk("abort_ready_after", 32'(ir1), 32'd1);
        chk("abort_result_after", 32'(r1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
